// File: rtl/kf8259_bus_master.sv
// -----------------------------------------------------------------------------
// kf8259_bus_master
// CPU-side bus initiator for the KF8259 interrupt controller register port.
// After an init_start pulse it writes ICW1, ICW2, ICW3 (cascade only),
// ICW4 (IC4 only) and, when KF8259_INIT_MASK_EN is defined, OCW1. Between
// init sequences it performs single register reads/writes on request.
//
// Every access walks IDLE -> SETUP -> STROBE -> HOLD -> GAP. chip_select_n
// stays low across SETUP, STROBE and HOLD, so the 8259 sees the rising edge
// of write_enable_n while still selected (that edge is where it commits).
//
// Optional feature macro: KF8259_INIT_MASK_EN (append OCW1 to the init run).
//
// Parameters:
//   SETUP_CYCLES   cycles address/data/chip select lead the strobe (1..15)
//   STROBE_CYCLES  cycles the strobe is held low (1..15)
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   init_start, icw1..icw4, ocw1   init request and the words it samples
//   cmd_valid/cmd_ready            single-access handshake
//   cmd_write, cmd_address, cmd_data  access kind, A0 and write data
//   rsp_valid, rsp_data            read-data pulse and held read data
//   busy, init_done                activity and init-complete status
//   chip_select_n, write_enable_n, read_enable_n, address, data_bus_out,
//   data_bus_in                    8259 register port
// -----------------------------------------------------------------------------
module kf8259_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_address,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       init_done,
    output logic       chip_select_n,
    output logic       write_enable_n,
    output logic       read_enable_n,
    output logic       address,
    output logic [7:0] data_bus_out,
    input  logic [7:0] data_bus_in
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    localparam logic [2:0] STEP_ICW1 = 3'd0;
    localparam logic [2:0] STEP_ICW2 = 3'd1;
    localparam logic [2:0] STEP_ICW3 = 3'd2;
    localparam logic [2:0] STEP_ICW4 = 3'd3;
    localparam logic [2:0] STEP_OCW1 = 3'd4;
    localparam logic [2:0] STEP_NONE = 3'd5;

    state_t     state_r, state_nx;
    logic [3:0] cnt_r, cnt_nx;
    logic [2:0] step_r, step_nx, step_after_s;
    logic       init_active_r, init_active_nx;
    logic       init_done_r, init_done_nx;
    logic       is_write_r, is_write_nx;
    logic       addr_r, addr_nx;
    logic [7:0] dout_r, dout_nx;
    logic [7:0] rsp_data_r, rsp_data_nx;
    logic       rsp_valid_r, rsp_valid_nx;
    logic       cs_n_r, cs_n_nx, we_n_r, we_n_nx, re_n_r, re_n_nx;
    logic       busy_r, busy_nx, idle_r, idle_nx;
    logic       capture_init_s, capture_rsp_s;
    logic [8:0] word_s;
    logic [7:0] icw1_r, icw2_r, icw3_r, icw4_r;
    logic [7:0] ocw1_s;

`ifdef KF8259_INIT_MASK_EN
    localparam logic MASK_EN = 1'b1;
    logic [7:0] ocw1_r;

    // OCW1 word captured together with the ICWs when init starts
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ocw1_r <= 8'h00;
        end else if (capture_init_s) begin
            ocw1_r <= ocw1;
        end else begin
            ocw1_r <= ocw1_r;
        end
    end
    assign ocw1_s = ocw1_r;
`else
    localparam logic MASK_EN = 1'b0;
    logic unused_ocw1_s;
    assign unused_ocw1_s = ^ocw1;
    assign ocw1_s        = 8'h00;
`endif

    // Next enabled init step after cur; STEP_NONE ends the sequence.
    // ICW3 only in cascade mode (icw1[1]=0), ICW4 only when IC4 (icw1[0]=1).
    function automatic logic [2:0] next_step(input logic [2:0] cur, input logic [7:0] w1);
        logic en_icw3, en_icw4;
        en_icw3 = ~w1[1];
        en_icw4 = w1[0];
        case (cur)
            STEP_ICW1: next_step = STEP_ICW2;
            STEP_ICW2: next_step = en_icw3 ? STEP_ICW3 : (en_icw4 ? STEP_ICW4 : (MASK_EN ? STEP_OCW1 : STEP_NONE));
            STEP_ICW3: next_step = en_icw4 ? STEP_ICW4 : (MASK_EN ? STEP_OCW1 : STEP_NONE);
            STEP_ICW4: next_step = MASK_EN ? STEP_OCW1 : STEP_NONE;
            default:   next_step = STEP_NONE;
        endcase
    endfunction

    // {A0, data} for an init step; bit 4 of ICW1 is forced so it decodes as ICW1
    function automatic logic [8:0] step_word(input logic [2:0] step, input logic [7:0] w1,
                                             input logic [7:0] w2, input logic [7:0] w3,
                                             input logic [7:0] w4, input logic [7:0] o1);
        case (step)
            STEP_ICW1: step_word = {1'b0, w1 | 8'h10};
            STEP_ICW2: step_word = {1'b1, w2};
            STEP_ICW3: step_word = {1'b1, w3};
            STEP_ICW4: step_word = {1'b1, w4};
            STEP_OCW1: step_word = {1'b1, o1};
            default:   step_word = 9'h000;
        endcase
    endfunction

    assign cmd_ready = idle_r & ~init_start;

    // Next-state, sequencer and next-output decode
    always_comb begin
        state_nx       = state_r;
        cnt_nx         = cnt_r + 4'd1;
        step_nx        = step_r;
        step_after_s   = STEP_NONE;
        init_active_nx = init_active_r;
        init_done_nx   = init_done_r;
        is_write_nx    = is_write_r;
        addr_nx        = addr_r;
        dout_nx        = dout_r;
        capture_init_s = 1'b0;
        word_s         = 9'h000;
        case (state_r)
            ST_IDLE: begin
                cnt_nx = 4'd0;
                if (init_start) begin
                    state_nx       = ST_SETUP;
                    step_nx        = STEP_ICW1;
                    init_active_nx = 1'b1;
                    init_done_nx   = 1'b0;
                    capture_init_s = 1'b1;
                    is_write_nx    = 1'b1;
                    word_s         = step_word(STEP_ICW1, icw1, icw2, icw3, icw4, ocw1_s);
                    addr_nx        = word_s[8];
                    dout_nx        = word_s[7:0];
                end else if (cmd_valid && cmd_ready) begin
                    state_nx    = ST_SETUP;
                    is_write_nx = cmd_write;
                    addr_nx     = cmd_address;
                    dout_nx     = cmd_data;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_nx = ST_STROBE;
                    cnt_nx   = 4'd0;
                end else begin
                    state_nx = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (cnt_r == STROBE_LAST) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = 4'd0;
                end else begin
                    state_nx = ST_STROBE;
                end
            end
            ST_HOLD: begin
                state_nx = ST_GAP;
                cnt_nx   = 4'd0;
            end
            ST_GAP: begin
                cnt_nx = 4'd0;
                if (init_active_r) begin
                    // Chain straight into the next enabled step: skipped steps cost nothing
                    step_after_s = next_step(step_r, icw1_r);
                    if (step_after_s == STEP_NONE) begin
                        state_nx       = ST_IDLE;
                        init_active_nx = 1'b0;
                        init_done_nx   = 1'b1;
                    end else begin
                        state_nx    = ST_SETUP;
                        step_nx     = step_after_s;
                        is_write_nx = 1'b1;
                        word_s      = step_word(step_after_s, icw1_r, icw2_r, icw3_r, icw4_r, ocw1_s);
                        addr_nx     = word_s[8];
                        dout_nx     = word_s[7:0];
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase

        cs_n_nx       = ~((state_nx == ST_SETUP) || (state_nx == ST_STROBE) || (state_nx == ST_HOLD));
        we_n_nx       = ~((state_nx == ST_STROBE) && is_write_nx);
        re_n_nx       = ~((state_nx == ST_STROBE) && !is_write_nx);
        rsp_valid_nx  = (state_nx == ST_HOLD) && !is_write_nx;
        // Read data is taken on the last strobe cycle, i.e. on the STROBE->HOLD edge
        capture_rsp_s = (state_r == ST_STROBE) && (state_nx == ST_HOLD) && !is_write_r;
        rsp_data_nx   = capture_rsp_s ? data_bus_in : rsp_data_r;
        busy_nx       = (state_nx != ST_IDLE);
        idle_nx       = (state_nx == ST_IDLE);
    end

    // State, sequencer and registered bus/status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            step_r        <= STEP_ICW1;
            init_active_r <= 1'b0;
            init_done_r   <= 1'b0;
            is_write_r    <= 1'b0;
            addr_r        <= 1'b0;
            dout_r        <= 8'h00;
            rsp_data_r    <= 8'h00;
            rsp_valid_r   <= 1'b0;
            cs_n_r        <= 1'b1;
            we_n_r        <= 1'b1;
            re_n_r        <= 1'b1;
            busy_r        <= 1'b0;
            idle_r        <= 1'b0;
        end else begin
            state_r       <= state_nx;
            cnt_r         <= cnt_nx;
            step_r        <= step_nx;
            init_active_r <= init_active_nx;
            init_done_r   <= init_done_nx;
            is_write_r    <= is_write_nx;
            addr_r        <= addr_nx;
            dout_r        <= dout_nx;
            rsp_data_r    <= rsp_data_nx;
            rsp_valid_r   <= rsp_valid_nx;
            cs_n_r        <= cs_n_nx;
            we_n_r        <= we_n_nx;
            re_n_r        <= re_n_nx;
            busy_r        <= busy_nx;
            idle_r        <= idle_nx;
        end
    end

    // ICW words sampled once at init start so later input changes cannot corrupt the run
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            icw1_r <= 8'h00;
            icw2_r <= 8'h00;
            icw3_r <= 8'h00;
            icw4_r <= 8'h00;
        end else if (capture_init_s) begin
            icw1_r <= icw1;
            icw2_r <= icw2;
            icw3_r <= icw3;
            icw4_r <= icw4;
        end else begin
            icw1_r <= icw1_r;
            icw2_r <= icw2_r;
            icw3_r <= icw3_r;
            icw4_r <= icw4_r;
        end
    end

    assign chip_select_n  = cs_n_r;
    assign write_enable_n = we_n_r;
    assign read_enable_n  = re_n_r;
    assign address        = addr_r;
    assign data_bus_out   = dout_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_data       = rsp_data_r;
    assign busy           = busy_r;
    assign init_done      = init_done_r;

endmodule

// File: tb/tb_kf8259_bus_master.sv
// -----------------------------------------------------------------------------
// tb_kf8259_bus_master
// Self-checking bench for kf8259_bus_master. A bus monitor decodes 8259 write
// commits (rising write_enable_n while selected) into a queue and checks
// strobe/select widths; directed and random init runs and single accesses are
// compared against a reference list built from the init rules.
// -----------------------------------------------------------------------------
module tb_kf8259_bus_master;

    localparam int S   = 1;
    localparam int T   = 2;
    localparam int ACC = S + T + 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       init_start;
    logic [7:0] icw1, icw2, icw3, icw4, ocw1;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_address;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy, init_done;
    logic       chip_select_n, write_enable_n, read_enable_n, address;
    logic [7:0] data_bus_out, data_bus_in;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] last_rsp = 8'h00;
    logic [8:0] wr_q[$];

    kf8259_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T)) dut (
        .clock(clock), .reset_n(reset_n), .init_start(init_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .init_done(init_done),
        .chip_select_n(chip_select_n), .write_enable_n(write_enable_n),
        .read_enable_n(read_enable_n), .address(address),
        .data_bus_out(data_bus_out), .data_bus_in(data_bus_in)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled mid-cycle
    logic prev_we = 1'b1, prev_re = 1'b1;
    int   we_run = 0, re_run = 0, cs_run = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_we <= 1'b1;
            prev_re <= 1'b1;
            we_run  <= 0;
            re_run  <= 0;
            cs_run  <= 0;
        end else begin
            if (!write_enable_n || !read_enable_n) begin
                check_value("strobe_inside_cs", chip_select_n, 0);
                check_value("strobe_exclusive", write_enable_n | read_enable_n, 1);
            end
            if (!write_enable_n) we_run <= we_run + 1;
            else if (!prev_we) begin
                check_value("we_width", we_run, T);
                check_value("cs_at_commit", chip_select_n, 0);
                wr_q.push_back({address, data_bus_out});
                we_run <= 0;
            end
            if (!read_enable_n) re_run <= re_run + 1;
            else if (!prev_re) begin
                check_value("re_width", re_run, T);
                re_run <= 0;
            end
            if (!chip_select_n) cs_run <= cs_run + 1;
            else if (cs_run != 0) begin
                check_value("cs_width", cs_run, S + T + 1);
                cs_run <= 0;
            end
            prev_we <= write_enable_n;
            prev_re <= read_enable_n;
        end
    end

    // Init run; optionally a write command is raised in the same cycle as init_start
    task automatic run_init(input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3,
                            input logic [7:0] w4, input logic [7:0] o1, input bit with_cmd,
                            input logic ca, input logic [7:0] cd);
        logic [8:0] exp_q[$];
        int base, n, k_done;
        exp_q.push_back({1'b0, w1 | 8'h10});
        exp_q.push_back({1'b1, w2});
        if (!w1[1]) exp_q.push_back({1'b1, w3});
        if (w1[0])  exp_q.push_back({1'b1, w4});
`ifdef KF8259_INIT_MASK_EN
        exp_q.push_back({1'b1, o1});
`endif
        n      = exp_q.size();
        base   = wr_q.size();
        k_done = -1;
        @(posedge clock); #1;
        icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; ocw1 = o1;
        init_start = 1'b1;
        if (with_cmd) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = ca; cmd_data = cd;
        end
        @(negedge clock);
        check_value("ready_vs_init_start", cmd_ready, 0);
        @(posedge clock); #1;
        init_start = 1'b0;
        icw1 = 8'($urandom); icw2 = 8'($urandom); icw3 = 8'($urandom);
        icw4 = 8'($urandom); ocw1 = 8'($urandom);
        for (int k = 1; k <= 200 && k_done < 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                check_value("init_busy_rise", busy, 1);
                check_value("init_done_cleared", init_done, 0);
            end
            if (k == 2) check_value("ready_during_init", cmd_ready, 0);
            if (init_done) k_done = k;
        end
        check_value("init_done_cycle", k_done, ACC * n + 1);
        check_value("busy_at_done", busy, 0);
        check_value("init_write_count", wr_q.size() - base, n);
        if (wr_q.size() - base == n) begin
            for (int i = 0; i < n; i++) check_value("init_write_word", wr_q[base + i], exp_q[i]);
        end
        if (with_cmd) begin
            check_value("ready_after_init", cmd_ready, 1);
            @(posedge clock); #1;
            cmd_valid = 1'b0;
            repeat (ACC + 1) @(negedge clock);
            check_value("queued_cmd_count", wr_q.size() - base, n + 1);
            if (wr_q.size() - base == n + 1) check_value("queued_cmd_word", wr_q[base + n], {ca, cd});
        end
    endtask

    task automatic single_access(input bit wr, input logic a, input logic [7:0] d, input logic [7:0] din);
        int base, rsp_k, pulses;
        base   = wr_q.size();
        rsp_k  = -1;
        pulses = 0;
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_data = d; data_bus_in = din;
        @(negedge clock);
        check_value("ready_idle", cmd_ready, 1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k <= ACC; k++) begin
            @(negedge clock);
            if (rsp_valid) begin
                pulses++;
                if (rsp_k < 0) rsp_k = k;
            end
            if (k == 0) begin
                check_value("acc_busy_rise", busy, 1);
                check_value("acc_address", address, a);
                if (wr) check_value("acc_data_out", data_bus_out, d);
            end
            if (k == ACC - 1) check_value("acc_busy_gap", busy, 1);
            if (k == ACC)     check_value("acc_busy_fall", busy, 0);
        end
        if (!wr) begin
            check_value("rsp_latency", rsp_k, S + T);
            check_value("rsp_pulses", pulses, 1);
            check_value("rsp_data", rsp_data, din);
            check_value("read_no_write", wr_q.size() - base, 0);
            last_rsp = din;
        end else begin
            check_value("write_no_rsp", pulses, 0);
            check_value("rsp_data_held", rsp_data, last_rsp);
            check_value("write_count", wr_q.size() - base, 1);
            if (wr_q.size() - base == 1) check_value("write_word", wr_q[base], {a, d});
        end
        data_bus_in = 8'($urandom);
    endtask

    initial begin
        int base, k;
        reset_n = 1'b0; init_start = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_address = 1'b0; cmd_data = 8'h00; data_bus_in = 8'h00;
        icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; ocw1 = 8'h00;
        repeat (3) @(negedge clock);
        check_value("rst_cs_n", chip_select_n, 1);
        check_value("rst_we_n", write_enable_n, 1);
        check_value("rst_re_n", read_enable_n, 1);
        check_value("rst_address", address, 0);
        check_value("rst_data_out", data_bus_out, 0);
        check_value("rst_rsp_data", rsp_data, 0);
        check_value("rst_rsp_valid", rsp_valid, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_init_done", init_done, 0);
        check_value("rst_cmd_ready", cmd_ready, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Test-plan init words, then the single-step-mode/no-IC4 case
        run_init(8'h11, 8'h08, 8'h04, 8'h01, 8'hFC, 1'b0, 1'b0, 8'h00);
        run_init(8'h02, 8'h20, 8'h33, 8'h44, 8'h55, 1'b0, 1'b0, 8'h00);
        single_access(1'b0, 1'b0, 8'h00, 8'h5A);
        run_init(8'h13, 8'h40, 8'h00, 8'h03, 8'hA5, 1'b1, 1'b1, 8'hC3);

        // Reset asserted during the ICW2 strobe
        @(posedge clock); #1;
        icw1 = 8'h11; icw2 = 8'h08; icw3 = 8'h04; icw4 = 8'h01; ocw1 = 8'hFC;
        init_start = 1'b1;
        @(posedge clock); #1;
        init_start = 1'b0;
        k = 0;
        while (k < 100 && !(write_enable_n == 1'b0 && address == 1'b1)) begin
            @(negedge clock);
            k++;
        end
        check_value("reached_icw2_strobe", k < 100, 1);
        #1 reset_n = 1'b0;
        #1;
        check_value("midrst_cs_n", chip_select_n, 1);
        check_value("midrst_we_n", write_enable_n, 1);
        check_value("midrst_re_n", read_enable_n, 1);
        check_value("midrst_busy", busy, 0);
        check_value("midrst_address", address, 0);
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        last_rsp = 8'h00;
        base = wr_q.size();
        repeat (40) @(negedge clock);
        check_value("no_resume_writes", wr_q.size() - base, 0);
        check_value("no_resume_busy", busy, 0);
        check_value("no_resume_done", init_done, 0);

        // Randomized init runs and single accesses
        repeat (12) begin
            run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        repeat (40) begin
            single_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
